// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART subsystem.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

    localparam int UART_DATA_W = 8;

    // Whole system clocks per transmitted bit (truncating).
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter_core #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int ID_W = $clog2(NUM_REQ);

    int idx;

    // Scan requesters in priority order starting at rr_ptr; keep the first hit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!any_req && req[ID_W'(idx)]) begin
                any_req = 1'b1;
                winner  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Holds the transfer FSM, the data latch, the WAIT timeout counter and the ack/err pulses.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int CLK_FREQ    = 1000000,
    parameter int BAUD_RATE   = 9600,
    parameter int TIMEOUT_CYC = 12 * CLK_FREQ / BAUD_RATE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           err,
    output logic                         tx_start,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam bit TOUT_EN = (TIMEOUT_CYC != 0);
    // Keep the counter at least one bit wide so a disabled timeout still elaborates.
    localparam int TOUT_W  = TOUT_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_EN ? TIMEOUT_CYC - 1 : 0);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   ptr_next;
    logic              any_req;
    logic [TOUT_W-1:0] tout_cnt;
    logic              tout_hit;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ)
    ) u_core (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    assign tout_hit = TOUT_EN && (tout_cnt == TOUT_LAST);

    // Transfer FSM with all outputs registered; tx_done wins over a coincident timeout.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            ack      <= '0;
            err      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            tout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= ISSUE;
                        grant_id <= winner;
                        tx_data  <= req_data[winner * DATA_W +: DATA_W];
                        rr_ptr   <= ptr_next;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    tx_start <= 1'b0;
                    tout_cnt <= '0;
                end
                WAIT: begin
                    if (tx_done) begin
                        state <= DONE;
                        ack   <= NUM_REQ'(1) << grant_id;
                    end else if (tout_hit) begin
                        state <= DONE;
                        ack   <= NUM_REQ'(1) << grant_id;
                        err   <= NUM_REQ'(1) << grant_id;
                    end else begin
                        tout_cnt <= tout_cnt + TOUT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= '0;
                    err   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reset, table-driven grant order,
// hand-written corner sequences and randomized transfers against a transaction model.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int TOUT = 50;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [31:0]  req_data;
    logic [3:0]   ack;
    logic [3:0]   err;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_done;
    logic         busy;
    logic [1:0]   grant_id;

    int passed    = 0;
    int total     = 0;
    int model_ptr = 0;

    typedef struct {
        logic [3:0] req;
        int         exp_g;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (8),
        .CLK_FREQ    (1000000),
        .BAUD_RATE   (9600),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .grant_id (grant_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        tx_done = 1'b0;
        step();
        reset     = 1'b0;
        model_ptr = 0;
    endtask

    // Round-robin rule: first requester at or after ptr, wrapping modulo N.
    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int i = 0; i < N; i++)
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        return 0;
    endfunction

    // One full transfer starting from IDLE. done_at is the WAIT cycle index carrying tx_done
    // (negative: never). Leaves the DUT in its IDLE cycle after DONE.
    task automatic run_txn(input string tag, input logic [3:0] r, input logic [31:0] d,
                           input int exp_g, input int done_at, input bit drop_mid);
        bit         exp_err;
        logic [7:0] exp_byte;
        exp_err  = (done_at < 0) || (done_at > TOUT - 1);
        exp_byte = d[exp_g*8 +: 8];
        req      = r;
        req_data = d;
        step();
        check({tag, " tx_start"}, 32'(tx_start), 32'd1);
        check({tag, " grant_id"}, 32'(grant_id), 32'(exp_g));
        check({tag, " tx_data"},  32'(tx_data),  32'(exp_byte));
        check({tag, " busy_issue"}, 32'(busy), 32'd1);
        step();
        check({tag, " tx_start_low"}, 32'(tx_start), 32'd0);
        if (drop_mid) begin
            req      = '0;
            req_data = ~d;
        end
        for (int j = 0; j < TOUT; j++) begin
            check({tag, " ack_wait"}, 32'(ack), 32'd0);
            tx_done = (j == done_at);
            step();
            tx_done = 1'b0;
            if (j == done_at) break;
        end
        check({tag, " ack"}, 32'(ack), 32'(4'b0001 << exp_g));
        check({tag, " err"}, 32'(err), exp_err ? 32'(4'b0001 << exp_g) : 32'd0);
        check({tag, " tx_data_done"}, 32'(tx_data), 32'(exp_byte));
        check({tag, " busy_done"}, 32'(busy), 32'd1);
        req = req & ~(4'b0001 << exp_g);
        step();
        check({tag, " ack_clear"}, 32'(ack), 32'd0);
        check({tag, " err_clear"}, 32'(err), 32'd0);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        model_ptr = (exp_g + 1) % N;
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        int          da;
        bit          drop;

        // Grant order from a fresh reset (rr_ptr=0); bytes are 0xA0+index.
        tbl[0]  = '{4'b1111, 0};
        tbl[1]  = '{4'b1111, 1};
        tbl[2]  = '{4'b1111, 2};
        tbl[3]  = '{4'b1111, 3};
        tbl[4]  = '{4'b0101, 0};
        tbl[5]  = '{4'b0101, 2};
        tbl[6]  = '{4'b0101, 0};
        tbl[7]  = '{4'b0101, 2};
        tbl[8]  = '{4'b0010, 1};
        tbl[9]  = '{4'b1001, 3};
        tbl[10] = '{4'b0110, 1};
        tbl[11] = '{4'b1000, 3};
        tbl[12] = '{4'b0001, 0};

        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;

        check("rst busy",     32'(busy),     32'd0);
        check("rst tx_start", 32'(tx_start), 32'd0);
        check("rst ack",      32'(ack),      32'd0);
        check("rst err",      32'(err),      32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst tx_data",  32'(tx_data),  32'd0);

        // Single requester 1, byte 0x55, tx_done at absolute cycle 20.
        run_txn("single", 4'b0010, 32'h0000_5500, 1, 18, 1'b0);

        do_reset();
        for (int i = 0; i < 13; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].req, 32'hA3A2_A1A0, tbl[i].exp_g, i % 3, 1'b0);

        // tx_done while IDLE must be ignored.
        req     = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("idle_done ack",      32'(ack),      32'd0);
        check("idle_done busy",     32'(busy),     32'd0);
        check("idle_done tx_start", 32'(tx_start), 32'd0);
        step();
        check("idle_done ack2",  32'(ack),  32'd0);
        check("idle_done busy2", 32'(busy), 32'd0);

        // tx_done on the last timeout cycle wins; then a genuine timeout.
        run_txn("coincide", 4'b0100, 32'h00C4_0000, 2, TOUT - 1, 1'b0);
        run_txn("timeout",  4'b1000, 32'h3C00_0000, 3, -1, 1'b0);

        // Request dropped mid-transfer still completes with ack.
        run_txn("drop_mid", 4'b0001, 32'h0000_0077, 0, 5, 1'b1);

        // Reset during WAIT aborts silently and clears the round-robin pointer.
        req      = 4'b1000;
        req_data = 32'h9900_0000;
        step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = '0;
        check("rst_wait busy",     32'(busy),     32'd0);
        check("rst_wait tx_start", 32'(tx_start), 32'd0);
        check("rst_wait ack",      32'(ack),      32'd0);
        check("rst_wait grant_id", 32'(grant_id), 32'd0);
        model_ptr = 0;
        step();
        check("rst_wait ack_after", 32'(ack), 32'd0);
        check("rst_wait err_after", 32'(err), 32'd0);
        run_txn("rst_regrant", 4'b0110, 32'h0012_3400, 1, 3, 1'b0);

        // Randomized transfers checked against the round-robin transaction model.
        for (int k = 0; k < 40; k++) begin
            r  = 4'($urandom_range(1, 15));
            d  = $urandom;
            da = int'($urandom_range(0, 59));
            if (da > TOUT - 1) da = -1;
            drop = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", k), r, d, pick(r, model_ptr), da, drop);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
